// File: rtl/run_ctrl_watchdog.sv
// Run controller and watchdog for a DUT under test.
// Sequences DUT reset, supervises the run, records how it ended.
module run_ctrl_watchdog #(
  parameter int NUM_ERR      = 2,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 10000000,
  parameter int STALL_LIMIT  = 100000,
  parameter int DRAIN_CYCLES = 5,
  parameter int RST_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               dut_rst,
  input  logic               commit_valid,
  input  logic               halt,
  input  logic [NUM_ERR-1:0] err,
  output logic               finish,
  output logic               pass,
  output logic [2:0]         cause,
  output logic [NUM_ERR-1:0] err_src,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   commit_cnt
);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [2:0] C_HALT  = 3'd1;
  localparam logic [2:0] C_ERR   = 3'd2;
  localparam logic [2:0] C_TMO   = 3'd3;
  localparam logic [2:0] C_STALL = 3'd4;

  // A zero count still spends one cycle in RESET.
  localparam logic [31:0] RST_LAST =
    (RST_CYCLES > 1) ? 32'(RST_CYCLES - 1) : 32'd0;
  localparam logic [31:0] DRN_LAST =
    (DRAIN_CYCLES > 1) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

  localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_V = CNT_W'(STALL_LIMIT);

  state_t             state, state_n;
  logic [31:0]        rst_cnt, rst_cnt_n;
  logic [31:0]        drn_cnt, drn_cnt_n;
  logic [CNT_W-1:0]   stall_cnt, stall_n;
  logic [CNT_W-1:0]   cycle_n, commit_n;
  logic [2:0]         cause_n;
  logic               pass_n;
  logic [NUM_ERR-1:0] err_src_n;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign dut_rst = (state == S_RESET);
  assign finish  = (state == S_DONE);

  // Next-state and next-value logic; end events are prioritised.
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    drn_cnt_n = drn_cnt;
    stall_n   = stall_cnt;
    cycle_n   = cycle_cnt;
    commit_n  = commit_cnt;
    cause_n   = cause;
    pass_n    = pass;
    err_src_n = err_src;
    unique case (state)
      S_RESET: begin
        if (rst_cnt == RST_LAST) begin
          state_n = S_RUN;
        end else begin
          rst_cnt_n = rst_cnt + 32'd1;
        end
      end
      S_RUN: begin
        cycle_n = sat_inc(cycle_cnt);
        if (commit_valid) begin
          commit_n = sat_inc(commit_cnt);
          stall_n  = '0;
        end else begin
          stall_n  = sat_inc(stall_cnt);
        end
        if (|err) begin
          err_src_n = err;
          cause_n   = C_ERR;
          drn_cnt_n = 32'd0;
          state_n   = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else if (halt) begin
          cause_n = C_HALT;
          pass_n  = 1'b1;
          state_n = S_DONE;
        end else if (cycle_n == TMO_V) begin
          cause_n = C_TMO;
          state_n = S_DONE;
        end else if (STALL_LIMIT != 0 && stall_n == STALL_V) begin
          cause_n = C_STALL;
          state_n = S_DONE;
        end
      end
      S_DRAIN: begin
        cycle_n   = sat_inc(cycle_cnt);
        if (commit_valid) commit_n = sat_inc(commit_cnt);
        err_src_n = err_src | err;
        if (drn_cnt == DRN_LAST) begin
          state_n = S_DONE;
        end else begin
          drn_cnt_n = drn_cnt + 32'd1;
        end
      end
      S_DONE: begin
      end
      default: state_n = S_RESET;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      rst_cnt    <= '0;
      drn_cnt    <= '0;
      stall_cnt  <= '0;
      cycle_cnt  <= '0;
      commit_cnt <= '0;
      cause      <= '0;
      pass       <= 1'b0;
      err_src    <= '0;
    end else begin
      state      <= state_n;
      rst_cnt    <= rst_cnt_n;
      drn_cnt    <= drn_cnt_n;
      stall_cnt  <= stall_n;
      cycle_cnt  <= cycle_n;
      commit_cnt <= commit_n;
      cause      <= cause_n;
      pass       <= pass_n;
      err_src    <= err_src_n;
    end
  end

endmodule

// File: tb/tb_run_ctrl_watchdog.sv
// Directed bench for run_ctrl_watchdog.
// Expected end-of-run records are queued and checked at finish.
module tb_run_ctrl_watchdog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dut_rst;
  logic        commit_valid = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  err = 2'b00;
  logic        finish;
  logic        pass;
  logic [2:0]  cause;
  logic [1:0]  err_src;
  logic [15:0] cycle_cnt;
  logic [15:0] commit_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  cause;
    logic        pass;
    logic [1:0]  err_src;
    logic [15:0] cyc;
    logic [15:0] com;
  } exp_t;

  exp_t sb[$];

  run_ctrl_watchdog #(
    .NUM_ERR(2),
    .CNT_W(16),
    .TIMEOUT(20),
    .STALL_LIMIT(8),
    .DRAIN_CYCLES(5),
    .RST_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dut_rst(dut_rst),
    .commit_valid(commit_valid),
    .halt(halt),
    .err(err),
    .finish(finish),
    .pass(pass),
    .cause(cause),
    .err_src(err_src),
    .cycle_cnt(cycle_cnt),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic p,
                      input logic [1:0] e, input int cy,
                      input int co);
    exp_t x;
    x.cause   = c;
    x.pass    = p;
    x.err_src = e;
    x.cyc     = 16'(cy);
    x.com     = 16'(co);
    sb.push_back(x);
  endtask

  task automatic sb_check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_finish"}, 32'(finish), 32'd1);
      chk({tag, "_cause"}, 32'(cause), 32'(x.cause));
      chk({tag, "_pass"}, 32'(pass), 32'(x.pass));
      chk({tag, "_err_src"}, 32'(err_src), 32'(x.err_src));
      chk({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'(x.cyc));
      chk({tag, "_commit_cnt"}, 32'(commit_cnt), 32'(x.com));
    end
  endtask

  // Pulse rst, check reset values, check RESET ignores inputs.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    chk({tag, "_rst_dut_rst"}, 32'(dut_rst), 32'd1);
    chk({tag, "_rst_finish"}, 32'(finish), 32'd0);
    chk({tag, "_rst_pass"}, 32'(pass), 32'd0);
    chk({tag, "_rst_cause"}, 32'(cause), 32'd0);
    chk({tag, "_rst_err_src"}, 32'(err_src), 32'd0);
    chk({tag, "_rst_cyc"}, 32'(cycle_cnt), 32'd0);
    chk({tag, "_rst_com"}, 32'(commit_cnt), 32'd0);
    rst = 1'b0;
    commit_valid = 1'b1;
    halt = 1'b1;
    err = 2'b11;
    chk({tag, "_dut_rst_c1"}, 32'(dut_rst), 32'd1);
    step();
    chk({tag, "_dut_rst_c2"}, 32'(dut_rst), 32'd1);
    step();
    chk({tag, "_dut_rst_run"}, 32'(dut_rst), 32'd0);
    commit_valid = 1'b0;
    halt = 1'b0;
    err = 2'b00;
    chk({tag, "_run_cyc0"}, 32'(cycle_cnt), 32'd0);
    chk({tag, "_run_cause0"}, 32'(cause), 32'd0);
    chk({tag, "_run_err0"}, 32'(err_src), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    step();

    // Halt in RUN cycle 10 with a commit every cycle.
    do_reset("halt");
    push(3'd1, 1'b1, 2'b00, 10, 10);
    for (int k = 1; k <= 10; k++) begin
      commit_valid = 1'b1;
      halt = (k == 10);
      step();
      chk($sformatf("halt_fin_k%0d", k), 32'(finish),
          32'(k == 10));
    end
    halt = 1'b0;
    for (int k = 0; k < 3; k++) step();
    sb_check("halt");

    // Error then second error during drain.
    do_reset("err");
    push(3'd2, 1'b0, 2'b11, 9, 9);
    for (int k = 1; k <= 9; k++) begin
      commit_valid = 1'b1;
      err = (k == 4) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00;
      step();
      chk($sformatf("err_fin_k%0d", k), 32'(finish),
          32'(k == 9));
      if (k == 4) begin
        chk("err_drain_cause", 32'(cause), 32'd2);
        chk("err_drain_src", 32'(err_src), 32'd1);
        chk("err_drain_pass", 32'(pass), 32'd0);
      end
    end
    err = 2'b00;
    step();
    sb_check("err");

    // Timeout at cycle 20.
    do_reset("tmo");
    push(3'd3, 1'b0, 2'b00, 20, 20);
    for (int k = 1; k <= 20; k++) begin
      commit_valid = 1'b1;
      step();
      chk($sformatf("tmo_fin_k%0d", k), 32'(finish),
          32'(k == 20));
    end
    step();
    step();
    sb_check("tmo");

    // Stall after three commits.
    do_reset("stall");
    push(3'd4, 1'b0, 2'b00, 11, 3);
    for (int k = 1; k <= 11; k++) begin
      commit_valid = (k <= 3);
      step();
      chk($sformatf("stall_fin_k%0d", k), 32'(finish),
          32'(k == 11));
    end
    commit_valid = 1'b0;
    step();
    sb_check("stall");

    // Halt and error together; later halt ignored in drain.
    do_reset("simul");
    push(3'd2, 1'b0, 2'b10, 8, 8);
    for (int k = 1; k <= 8; k++) begin
      commit_valid = 1'b1;
      halt = (k >= 3);
      err = (k == 3) ? 2'b10 : 2'b00;
      step();
      chk($sformatf("simul_fin_k%0d", k), 32'(finish),
          32'(k == 8));
      if (k == 3) begin
        chk("simul_cause", 32'(cause), 32'd2);
        chk("simul_pass", 32'(pass), 32'd0);
      end
    end
    halt = 1'b0;
    sb_check("simul");

    // Reset while draining, then a normal halted run.
    do_reset("mid");
    for (int k = 1; k <= 4; k++) begin
      commit_valid = 1'b1;
      err = (k == 2) ? 2'b01 : 2'b00;
      step();
    end
    chk("mid_in_drain_fin", 32'(finish), 32'd0);
    chk("mid_in_drain_cause", 32'(cause), 32'd2);
    do_reset("mid2");
    push(3'd1, 1'b1, 2'b00, 3, 3);
    for (int k = 1; k <= 3; k++) begin
      commit_valid = 1'b1;
      halt = (k == 3);
      step();
    end
    halt = 1'b0;
    commit_valid = 1'b0;
    sb_check("mid2");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl_watchdog.md
RUN_CTRL_WATCHDOG -- requirements
Module: run_ctrl_watchdog

Interface
REQ-001 SHALL have parameter NUM_ERR, default 2: number of independent error sources.
REQ-002 SHALL have parameter CNT_W, default 32: width of the cycle, commit and stall counters.
REQ-003 SHALL have parameter TIMEOUT, default 10000000: maximum number of RUN cycles before a forced stop.
REQ-004 SHALL have parameter STALL_LIMIT, default 100000: maximum number of consecutive RUN cycles without a commit; 0 disables the stall check.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 5: number of cycles between an error and the stop.
REQ-006 SHALL have parameter RST_CYCLES, default 2: number of cycles the DUT reset is held after the block leaves reset.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port dut_rst, output, 1 bit: reset to the DUT, active-high.
REQ-010 SHALL have port commit_valid, input, 1 bit: the DUT retired an instruction this cycle.
REQ-011 SHALL have port halt, input, 1 bit: the DUT requests a normal end of run.
REQ-012 SHALL have port err, input, NUM_ERR bits: per-source error flags, sampled every cycle.
REQ-013 SHALL have port finish, output, 1 bit: the run has ended (level).
REQ-014 SHALL have port pass, output, 1 bit: the run ended by halt with no error.
REQ-015 SHALL have port cause, output, 3 bits: end cause; 0 NONE, 1 HALT, 2 ERROR, 3 TIMEOUT, 4 STALL.
REQ-016 SHALL have port err_src, output, NUM_ERR bits: sticky record of the error sources that fired.
REQ-017 SHALL have port cycle_cnt, output, CNT_W bits: count of RUN and DRAIN cycles.
REQ-018 SHALL have port commit_cnt, output, CNT_W bits: count of commit_valid cycles in RUN and DRAIN.

Function
REQ-019 SHALL implement the states RESET, RUN, DRAIN and DONE, all registered.
REQ-020 SHALL, in RESET, drive dut_rst=1 for exactly RST_CYCLES cycles, ignore all inputs, then enter RUN with dut_rst=0.
REQ-021 SHALL, in RUN, increment cycle_cnt every cycle and commit_cnt on each cycle with commit_valid=1.
REQ-022 SHALL, in RUN, clear the stall counter on commit_valid=1 and increment it otherwise.
REQ-023 SHALL, in RUN, check end events in the order error > halt > timeout > stall; only the highest-priority event present in a cycle takes effect.
REQ-024 SHALL, on any err bit =1 in RUN, set err_src=err, set cause=2 and enter DRAIN; enter DONE directly when DRAIN_CYCLES=0.
REQ-025 SHALL, on halt=1 with no error in RUN, set cause=1 and pass=1 and enter DONE on the next cycle.
REQ-026 SHALL raise a timeout (cause=3) in the cycle where cycle_cnt reaches TIMEOUT, and enter DONE.
REQ-027 SHALL, when STALL_LIMIT>0, raise a stall (cause=4) in the cycle where the stall counter reaches STALL_LIMIT, and enter DONE.
REQ-028 SHALL, in DRAIN, remain for exactly DRAIN_CYCLES cycles and then enter DONE.
REQ-029 SHALL, in DRAIN, keep cycle_cnt and commit_cnt counting, OR newly asserted err bits into err_src, and ignore halt, timeout and stall.
REQ-030 SHALL, in DONE, hold finish=1, freeze all counters and outputs, and stay there until rst.
REQ-031 SHALL saturate all counters at all-ones with no wrap-around.
REQ-032 SHALL keep pass=0 whenever cause is not 1.

Reset
REQ-033 SHALL, while rst=1, force state=RESET, dut_rst=1, finish=0, pass=0, cause=0, err_src=0 and all counters to 0.
REQ-034 SHALL, on rst=1 in any state including mid-DRAIN, take that reset on the next clock edge and restart the RST_CYCLES sequence.

Verification
Parameters for all scenarios: TIMEOUT=20, STALL_LIMIT=8, DRAIN_CYCLES=5, RST_CYCLES=2, NUM_ERR=2.
REQ-035 SHALL cover halt: release rst, commit every cycle, halt in RUN cycle 10 -> dut_rst=0 after 2 cycles; finish=1 next cycle; pass=1, cause=1, commit_cnt=10.
REQ-036 SHALL cover error with drain: err=2'b01 at RUN cycle 4, err=2'b10 two cycles later -> finish rises 5 cycles after the first error; err_src=2'b11, cause=2, pass=0.
REQ-037 SHALL cover timeout: commit every cycle, no halt -> finish at cycle_cnt=20, cause=3, cycle_cnt frozen at 20.
REQ-038 SHALL cover stall: commit for 3 cycles, then none -> cause=4 after 8 idle cycles; commit_cnt=3.
REQ-039 SHALL cover simultaneous events: halt=1 and err=2'b10 in the same cycle -> DRAIN entered, cause=2, pass=0, and the later halt is ignored.
REQ-040 SHALL cover reset mid-operation: rst pulsed during DRAIN -> all outputs reset, dut_rst=1 for 2 cycles, normal RUN resumes.
